// File: rtl/ff_excitation_gen.sv
// Derives JK/SR/T excitation from a desired-next-state stream and checks it against a flip-flop model.
// Latency: excitation N+1, model/err N+2; no backpressure, one sample per cycle.
module ff_excitation_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             d_next,
    input  logic [1:0]       mode,
    input  logic             fault_inj,
    output logic             J,
    output logic             K,
    output logic             S,
    output logic             R,
    output logic             T,
    output logic             out_valid,
    output logic             q_model,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0] MODE_SR = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic       q_exp;
    logic       d_exp;
    logic [1:0] exc_mode;

    logic j_c, k_c, s_c, r_c, t_c;
    logic q_nxt, sr_bad, mism;

    // Don't-cares resolve to 0; the fault flips only the primary bit.
    always_comb begin
        j_c = 1'b0;
        k_c = 1'b0;
        s_c = 1'b0;
        r_c = 1'b0;
        t_c = 1'b0;
        case (mode)
            MODE_SR: begin
                s_c = (~q_exp & d_next) ^ fault_inj;
                r_c = q_exp & ~d_next;
            end
            MODE_T: begin
                t_c = (q_exp ^ d_next) ^ fault_inj;
            end
            default: begin
                j_c = (~q_exp & d_next) ^ fault_inj;
                k_c = q_exp & ~d_next;
            end
        endcase
    end

    always_comb begin
        sr_bad = 1'b0;
        q_nxt  = q_model;
        case (exc_mode)
            MODE_SR: begin
                sr_bad = S & R;
                q_nxt  = sr_bad ? q_model : (S | (~R & q_model));
            end
            MODE_T: begin
                q_nxt = q_model ^ T;
            end
            default: begin
                q_nxt = (J & ~q_model) | (~K & q_model);
            end
        endcase
        mism = sr_bad | (q_nxt != d_exp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            J         <= 1'b0;
            K         <= 1'b0;
            S         <= 1'b0;
            R         <= 1'b0;
            T         <= 1'b0;
            out_valid <= 1'b0;
            q_exp     <= 1'b0;
            d_exp     <= 1'b0;
            exc_mode  <= 2'b00;
            q_model   <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (in_valid) begin
                J         <= j_c;
                K         <= k_c;
                S         <= s_c;
                R         <= r_c;
                T         <= t_c;
                out_valid <= 1'b1;
                q_exp     <= d_next;
                d_exp     <= d_next;
                exc_mode  <= mode;
            end else begin
                J         <= 1'b0;
                K         <= 1'b0;
                S         <= 1'b0;
                R         <= 1'b0;
                T         <= 1'b0;
                out_valid <= 1'b0;
            end

            // The model is never resynchronised to q_exp after a mismatch.
            if (out_valid) begin
                q_model <= q_nxt;
                err     <= mism;
                if (mism && (err_cnt != CNT_MAX))
                    err_cnt <= err_cnt + CNT_ONE;
            end else begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ff_excitation_gen.sv
// Directed bench for ff_excitation_gen: default-width instance plus a CNT_W=2 instance for saturation.
module tb_ff_excitation_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       d_next;
    logic [1:0] mode;
    logic       fault_inj;

    logic       J, K, S, R, T, out_valid, q_model, err;
    logic [7:0] err_cnt;
    logic       J2, K2, S2, R2, T2, out_valid2, q_model2, err2;
    logic [1:0] err_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] M_JK = 2'b00;
    localparam logic [1:0] M_SR = 2'b01;
    localparam logic [1:0] M_T  = 2'b10;

    always #5 clk = ~clk;

    ff_excitation_gen #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d_next(d_next), .mode(mode),
        .fault_inj(fault_inj), .J(J), .K(K), .S(S), .R(R), .T(T),
        .out_valid(out_valid), .q_model(q_model), .err(err), .err_cnt(err_cnt)
    );

    ff_excitation_gen #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d_next(d_next), .mode(mode),
        .fault_inj(fault_inj), .J(J2), .K(K2), .S(S2), .R(R2), .T(T2),
        .out_valid(out_valid2), .q_model(q_model2), .err(err2), .err_cnt(err_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then land 1 time unit after the capturing edge.
    task automatic step(input logic v, input logic d, input logic [1:0] m, input logic f);
        in_valid  = v;
        d_next    = d;
        mode      = m;
        fault_inj = f;
        @(posedge clk);
        #1;
    endtask

    // Per-sample tables: d_next and expected excitation bits
    logic jk_d   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] jk_exp [4] = '{2'b10, 2'b00, 2'b01, 2'b00};
    logic jk_q   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic sr_d   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] sr_exp [4] = '{2'b10, 2'b01, 2'b00, 2'b10};
    logic t_d    [3] = '{1'b1, 1'b1, 1'b0};
    logic t_exp  [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst = 1'b1;
        step(1'b0, 1'b0, M_JK, 1'b0);
        check("reset_outputs", {J, K, S, R, T, out_valid, q_model, err}, 8'h00);
        check("reset_cnt", err_cnt, 0);
        rst = 1'b0;

        // JK run: excitation at N+1, model result at N+2
        for (int i = 0; i < 4; i++) begin
            step(1'b1, jk_d[i], M_JK, 1'b0);
            check($sformatf("jk_exc%0d", i), {out_valid, J, K}, {1'b1, jk_exp[i]});
            if (i > 0) check($sformatf("jk_q%0d", i-1), {q_model, err}, {jk_q[i-1], 1'b0});
        end
        step(1'b0, 1'b0, M_JK, 1'b0);
        check("jk_q3", {q_model, err, out_valid, J, K}, {jk_q[3], 4'b0000});

        for (int i = 0; i < 4; i++) begin
            step(1'b1, sr_d[i], M_SR, 1'b0);
            check($sformatf("sr_exc%0d", i), {S, R, J, K, T}, {sr_exp[i], 3'b000});
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, t_d[i], M_T, 1'b0);
            check($sformatf("t_exc%0d", i), {T, J, K, S, R}, {t_exp[i], 4'b0000});
        end
        step(1'b0, 1'b0, M_JK, 1'b0);
        step(1'b0, 1'b0, M_JK, 1'b0);
        check("srt_state", {q_model, err}, 2'b00);
        check("srt_cnt", err_cnt, 0);

        // Faulted JK sample from q_exp=0 toward 1
        step(1'b1, 1'b1, M_JK, 1'b1);
        check("flt_exc", {out_valid, J, K}, 3'b100);
        step(1'b0, 1'b0, M_JK, 1'b0);
        check("flt_model", {q_model, err}, 2'b01);
        check("flt_cnt", err_cnt, 1);
        step(1'b0, 1'b0, M_JK, 1'b0);
        check("flt_pulse_end", {err, err_cnt}, {1'b0, 8'd1});

        // Reset with a sample in flight (q_exp=1, d=0 gives K=1)
        step(1'b1, 1'b0, M_JK, 1'b0);
        check("inflight_exc", {out_valid, J, K}, 3'b101);
        rst = 1'b1;
        step(1'b0, 1'b0, M_JK, 1'b0);
        rst = 1'b0;
        check("midrst_outputs", {J, K, S, R, T, out_valid, q_model, err}, 8'h00);
        check("midrst_cnt", err_cnt, 0);
        step(1'b1, 1'b1, M_JK, 1'b0);
        check("post_rst_exc", {out_valid, J, K}, 3'b110);
        step(1'b0, 1'b0, M_JK, 1'b0);
        check("post_rst_model", {q_model, err}, 2'b10);

        // Saturation: each faulted T d=0 fails; the JK d=1 after it resyncs the model.
        rst = 1'b1;
        step(1'b0, 1'b0, M_JK, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, M_T, 1'b1);
            check($sformatf("sat_quiet%0d", i), err2, 1'b0);
            step(1'b1, 1'b1, M_JK, 1'b0);
            check($sformatf("sat_err%0d", i), err2, 1'b1);
            check($sformatf("sat_cnt%0d", i), err_cnt2, sat_exp[i]);
        end
        step(1'b0, 1'b0, M_JK, 1'b0);
        check("sat_final", {err2, err_cnt2, q_model2}, {1'b0, 2'd3, 1'b1});
        check("wide_cnt", err_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ff_excitation_gen.md
# ff_excitation_gen

Excitation generator and checker for the flip-flop conversion family. It is the inverse of the "build JK/SR/T from a D flip-flop" blocks. Given a stream of desired next states, it derives the J/K, S/R or T inputs that drive a flip-flop from its current state to the desired one. It applies those inputs to an internal behavioural flip-flop model and flags any sample where the model does not land on the requested state. It sits beside the conversion designs as a self-checking stimulus source.

## Interface
Parameters:
- CNT_W, 8: width of the saturating mismatch counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- in_valid  input  1  d_next and mode are valid this cycle.
- d_next  input  1  desired next state of the target flip-flop.
- mode  input  2  00 = JK, 01 = SR, 10 = T, 11 = reserved (treated as JK).
- fault_inj  input  1  sampled with in_valid; inverts the primary excitation bit (J, S or T) of that sample.
- J, K  output  1 each  registered JK excitation.
- S, R  output  1 each  registered SR excitation.
- T  output  1  registered T excitation.
- out_valid  output  1  excitation outputs valid this cycle.
- q_model  output  1  state of the internal flip-flop model.
- err  output  1  one-cycle pulse on a model/expected mismatch.
- err_cnt  output  CNT_W  saturating mismatch count.

## Operation
- Internal registers:
  - q_exp: expected state after the last accepted sample.
  - exc_mode: mode captured with the excitation.
  - d_exp: expected target of the sample in flight.
- On an in_valid cycle, excitation is computed from q_exp and d_next. Don't-cares resolve to 0. The encodings not selected by mode are driven 0.
  - JK: if q_exp = 0, J = d_next and K = 0. If q_exp = 1, J = 0 and K = ~d_next.
  - SR: if q_exp = 0, S = d_next and R = 0. If q_exp = 1, S = 0 and R = ~d_next.
  - T: T = q_exp ^ d_next.
- fault_inj = 1 inverts J, S or T after encoding.
- At the same edge, the block updates q_exp <= d_next, d_exp <= d_next and exc_mode <= mode, and sets out_valid <= 1.
- Without in_valid, out_valid <= 0 and all excitation outputs <= 0. q_exp holds.
- Model update happens at the edge ending an out_valid cycle. It applies the registered excitation to q_model using the exc_mode characteristic equation:
  - JK: q = J&~q | ~K&q.
  - SR: q = S | ~R&q.
  - T: q = q ^ T.
- SR with S = R = 1 (reachable only via fault_inj) is illegal. q_model holds and the sample counts as a mismatch.
- Check, at the same edge: if the new q_model != d_exp, or the SR-illegal case occurs, err <= 1 and err_cnt increments, saturating at 2^CNT_W - 1. Otherwise err <= 0.
- After a mismatch, q_model and q_exp diverge. Later samples keep using q_exp for encoding, so subsequent checks may fail too. This is intended and is not resynchronised.
- mode may change on every sample. Each sample uses its own captured mode.

## Timing
- Reset values: J = K = S = R = T = 0, out_valid = 0, q_model = 0, err = 0, err_cnt = 0. q_exp = 0 and d_exp = 0.
- Reset takes priority over in_valid. Asserting reset mid-stream discards every in-flight sample with no err pulse.
- Throughput is one sample per cycle. Back-to-back in_valid is fully supported.
- Latency for a sample presented in cycle N:
  - Excitation and out_valid are visible in cycle N+1.
  - q_model and err are updated in cycle N+2.
- err is high for exactly one cycle per failing sample. Consecutive failing samples give consecutive err cycles.
- On saturation, err_cnt holds its maximum value and err still pulses.

## Test plan
- Reset, then JK mode with d_next = 1,1,0,0 on back-to-back cycles.
  - Required excitation (J,K) = (1,0),(0,0),(0,1),(0,0) in cycles 1–4 after the first in_valid.
  - Required q_model = 1,1,0,0 two cycles after each sample, with err never asserting.
- SR mode with d_next = 1,0,0,1, then T mode with d_next = 1,1,0.
  - Required (S,R) = (1,0),(0,1),(0,0),(1,0).
  - Required T = 0,0,1, since q_exp = 1 before the T run starts.
  - err_cnt must stay 0.
- fault_inj = 1 on a single JK sample with q_exp = 0 and d_next = 1.
  - Required J = 0 in cycle N+1, q_model = 0 in cycle N+2, a one-cycle err pulse and err_cnt = 1.
- CNT_W = 2 with 5 faulted T samples.
  - Required: err_cnt steps 1,2,3,3,3, with err pulsing on all 5.
- Assert rst for one cycle while an out_valid sample is in flight.
  - Required: all outputs 0 in the next cycle, no err pulse, and the next sample encodes from q_exp = 0.
